conv_pe_kxk: RTL and testbench

Parametrised K×K convolution processing element: multiplies a K×K signed data window by a K×K signed weight window, reduces the products through a pipelined adder tree, and accumulates across multiple input channels into one output pixel. An optional bias is added at the start of each group, and the result is saturated. It replaces the fixed 3×3 PE in the depthwise/standard convolution engines. Multi-channel accumulation, valid/first/last framing, reset and sequence-error detection are new behaviour.

---
 rtl/conv_pe_kxk.sv | 241 ++++++++++++++++++++++++
 tb/tb_conv_pe_kxk.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pe_kxk.sv
// KxK signed convolution PE: multiply, pipelined adder tree, multi-channel
// accumulate with bias, saturation, framing checks. Optional ReLU: PE_RELU_EN.
// Ports: clk, rst_n (async, active-low); in_valid/in_first/in_last/in_tag,
// data, weight, bias inputs; out_valid, result, out_tag, busy, err_seq outputs.
module conv_pe_kxk #(
  parameter int DATA_WIDTH = 16,
  parameter int KERNEL     = 3,
  parameter int ACC_WIDTH  = 40,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  input  logic                                   in_first,
  input  logic                                   in_last,
  input  logic [TAG_WIDTH-1:0]                   in_tag,
  input  logic [DATA_WIDTH*KERNEL*KERNEL-1:0]    data,
  input  logic [DATA_WIDTH*KERNEL*KERNEL-1:0]    weight,
  input  logic [2*DATA_WIDTH-1:0]                bias,
  output logic                                   out_valid,
  output logic [ACC_WIDTH-1:0]                   result,
  output logic [TAG_WIDTH-1:0]                   out_tag,
  output logic                                   busy,
  output logic                                   err_seq
);

  localparam int N   = KERNEL * KERNEL;
  localparam int LVL = (N > 1) ? $clog2(N) : 0;
  localparam int NP  = 1 << LVL;
  localparam int PW  = 2 * DATA_WIDTH;
  localparam int SW  = PW + LVL;
  localparam int VW  = DATA_WIDTH * N;

  // Framing tracker
  logic open_q, open_d;
  logic err_q, err_d;
  logic first_eff;
  logic bad;

  always_comb begin
    first_eff = in_first | ~open_q;
    // first while open, or non-first while closed
    bad       = in_valid & (in_first == open_q);
    open_d    = in_valid ? ~in_last : open_q;
    err_d     = err_q | bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      open_q <= open_d;
      err_q  <= err_d;
    end
  end

  // S1: input register
  logic                   s1_v_q, s1_f_q, s1_l_q;
  logic [TAG_WIDTH-1:0]   s1_tag_q;
  logic signed [PW-1:0]   s1_bias_q;
  logic [VW-1:0]          s1_dat_q, s1_wgt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_f_q    <= 1'b0;
      s1_l_q    <= 1'b0;
      s1_tag_q  <= '0;
      s1_bias_q <= '0;
      s1_dat_q  <= '0;
      s1_wgt_q  <= '0;
    end else begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_f_q    <= first_eff;
        s1_l_q    <= in_last;
        s1_tag_q  <= in_tag;
        s1_bias_q <= bias;
        s1_dat_q  <= data;
        s1_wgt_q  <= weight;
      end
    end
  end

  // S2: product register
  logic signed [PW-1:0] prod [N];
  logic signed [PW-1:0] s2_p_q [N];
  logic                 s2_v_q, s2_f_q, s2_l_q;
  logic [TAG_WIDTH-1:0] s2_tag_q;
  logic signed [PW-1:0] s2_bias_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      prod[i] = $signed(s1_dat_q[DATA_WIDTH*i +: DATA_WIDTH])
              * $signed(s1_wgt_q[DATA_WIDTH*i +: DATA_WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_f_q    <= 1'b0;
      s2_l_q    <= 1'b0;
      s2_tag_q  <= '0;
      s2_bias_q <= '0;
      for (int i = 0; i < N; i++) s2_p_q[i] <= '0;
    end else begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_f_q    <= s1_f_q;
        s2_l_q    <= s1_l_q;
        s2_tag_q  <= s1_tag_q;
        s2_bias_q <= s1_bias_q;
        for (int i = 0; i < N; i++) s2_p_q[i] <= prod[i];
      end
    end
  end

  // Adder tree: all nodes carry full SW width (already sign-extended);
  // a register follows every second level and the final level.
  logic [LVL:0] lvv;

  genvar gl, gi;
  generate
    for (gl = 0; gl <= LVL; gl++) begin : g_lv
      localparam int W = NP >> gl;
      logic signed [SW-1:0]  node [W];
      logic                  v, f, la;
      logic [TAG_WIDTH-1:0]  tg;
      logic signed [PW-1:0]  bs;

      if (gl == 0) begin : g_src
        for (gi = 0; gi < W; gi++) begin : g_e
          if (gi < N) begin : g_p
            assign node[gi] = SW'(s2_p_q[gi]);
          end else begin : g_z
            assign node[gi] = '0;
          end
        end
        assign v  = s2_v_q;
        assign f  = s2_f_q;
        assign la = s2_l_q;
        assign tg = s2_tag_q;
        assign bs = s2_bias_q;
      end else begin : g_add
        logic signed [SW-1:0] s [W];
        for (gi = 0; gi < W; gi++) begin : g_s
          assign s[gi] = g_lv[gl-1].node[2*gi] + g_lv[gl-1].node[2*gi+1];
        end
        if ((gl % 2 == 0) || (gl == LVL)) begin : g_reg
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
              v  <= 1'b0;
              f  <= 1'b0;
              la <= 1'b0;
              tg <= '0;
              bs <= '0;
              for (int i = 0; i < W; i++) node[i] <= '0;
            end else begin
              v <= g_lv[gl-1].v;
              if (g_lv[gl-1].v) begin
                f  <= g_lv[gl-1].f;
                la <= g_lv[gl-1].la;
                tg <= g_lv[gl-1].tg;
                bs <= g_lv[gl-1].bs;
                for (int i = 0; i < W; i++) node[i] <= s[i];
              end
            end
          end
        end else begin : g_cmb
          assign node = s;
          assign v    = g_lv[gl-1].v;
          assign f    = g_lv[gl-1].f;
          assign la   = g_lv[gl-1].la;
          assign tg   = g_lv[gl-1].tg;
          assign bs   = g_lv[gl-1].bs;
        end
      end
      assign lvv[gl] = v;
    end
  endgenerate

  // Accumulate stage
  logic signed [SW-1:0]        t_sum;
  logic                        t_v, t_f, t_l;
  logic [TAG_WIDTH-1:0]        t_tag;
  logic signed [PW-1:0]        t_bias;

  assign t_sum  = g_lv[LVL].node[0];
  assign t_v    = g_lv[LVL].v;
  assign t_f    = g_lv[LVL].f;
  assign t_l    = g_lv[LVL].la;
  assign t_tag  = g_lv[LVL].tg;
  assign t_bias = g_lv[LVL].bs;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, base, res_c;
  logic signed [ACC_WIDTH:0]   tot;
  logic                        ov_q;
  logic [ACC_WIDTH-1:0]        res_q;
  logic [TAG_WIDTH-1:0]        tag_q;

  always_comb begin
    base = t_f ? ACC_WIDTH'(t_bias) : acc_q;
    tot  = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(t_sum);
    if (tot[ACC_WIDTH] != tot[ACC_WIDTH-1]) begin
      acc_d = tot[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      acc_d = tot[ACC_WIDTH-1:0];
    end
`ifdef PE_RELU_EN
    res_c = acc_d[ACC_WIDTH-1] ? '0 : acc_d;
`else
    res_c = acc_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ov_q  <= 1'b0;
      res_q <= '0;
      tag_q <= '0;
    end else begin
      ov_q <= t_v & t_l;
      if (t_v) acc_q <= acc_d;
      if (t_v && t_l) begin
        res_q <= res_c;
        tag_q <= t_tag;
      end
    end
  end

  assign out_valid = ov_q;
  assign result    = res_q;
  assign out_tag   = tag_q;
  assign err_seq   = err_q;
  assign busy      = s1_v_q | (|lvv) | open_q;

endmodule

// File: tb/tb_conv_pe_kxk.sv
// Bench for conv_pe_kxk: vector table + scoreboard, plus framing,
// saturation and mid-flight reset sequences.
module tb_conv_pe_kxk;

  localparam int DW = 16;
  localparam int K  = 3;
  localparam int N  = K * K;
  localparam int LAT = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_first, in_last;
  logic [7:0]        in_tag;
  logic [DW*N-1:0]   data, weight;
  logic [2*DW-1:0]   bias;
  logic              out_valid, busy, err_seq;
  logic [39:0]       result;
  logic [7:0]        out_tag;
  logic              ov36, busy36, err36;
  logic [35:0]       res36;
  logic [7:0]        tag36;

  conv_pe_kxk #(.DATA_WIDTH(DW), .KERNEL(K), .ACC_WIDTH(40), .TAG_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .in_tag(in_tag), .data(data), .weight(weight),
    .bias(bias), .out_valid(out_valid), .result(result), .out_tag(out_tag),
    .busy(busy), .err_seq(err_seq));

  conv_pe_kxk #(.DATA_WIDTH(DW), .KERNEL(K), .ACC_WIDTH(36), .TAG_WIDTH(8)) dut36 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .in_tag(in_tag), .data(data), .weight(weight),
    .bias(bias), .out_valid(ov36), .result(res36), .out_tag(tag36),
    .busy(busy36), .err_seq(err36));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    longint     res;
    logic [7:0] tag;
    int         cyc;
  } sb_t;
  sb_t q[$];

  typedef struct {
    bit         f;
    bit         l;
    bit         ramp;
    logic [7:0] tag;
    int         dv;
    int         wv;
    int         bv;
    longint     exp;
  } vec_t;
  vec_t tbl[11];

  function automatic longint pe_out(longint v);
`ifdef PE_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(string nm, longint act, longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=1 required=0 cyc=%0d", cyc);
      end else begin
        sb_t e;
        e = q.pop_front();
        chk("sb_result", longint'($signed(result)), e.res);
        chk("sb_tag", longint'(out_tag), longint'(e.tag));
        chk("sb_latency", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  task automatic beat(bit f, bit l, bit ramp, logic [7:0] tg,
                      int dv, int wv, int bv, longint exp, bit push);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    in_tag   = tg;
    bias     = 32'(bv);
    for (int i = 0; i < N; i++) begin
      data[DW*i +: DW]   = ramp ? 16'(i) : 16'(dv);
      weight[DW*i +: DW] = ramp ? 16'(i) : 16'(wv);
    end
    if (push && l) begin
      sb_t e;
      e.res = pe_out(exp);
      e.tag = tg;
      e.cyc = cyc + LAT;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 50) begin
      idle(1);
      k++;
    end
    if (q.size() != 0) chk("drain_timeout", longint'(q.size()), 0);
  endtask

  initial begin
    int pulses;
    bit got;

    tbl[0]  = '{1, 1, 0, 8'h3A, 1, 2, 5, 23};
    tbl[1]  = '{1, 0, 0, 8'h00, 1, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 8'h00, 1, 1, 0, 0};
    tbl[3]  = '{0, 1, 0, 8'h11, 1, 1, 0, 27};
    tbl[4]  = '{1, 0, 0, 8'h00, 1, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 8'h00, 1, 1, 0, 0};
    tbl[6]  = '{0, 1, 0, 8'h12, 1, 1, 0, 27};
    tbl[7]  = '{1, 1, 0, 8'h21, -100, 100, 0, -90000};
    tbl[8]  = '{1, 1, 1, 8'h44, 0, 0, -4, 200};
    tbl[9]  = '{1, 1, 0, 8'h55, 32767, 32767, 32767, 64'sd9663119368};
    tbl[10] = '{1, 1, 0, 8'h56, 0, 5, -32768, -32768};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    in_tag   = '0;
    data     = '0;
    weight   = '0;
    bias     = '0;
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_result", longint'(result), 0);
    chk("rst_out_tag", longint'(out_tag), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_err_seq", longint'(err_seq), 0);
    idle(1);

    // Table: back-to-back beats, groups with no dead cycles
    for (int i = 0; i < 11; i++) begin
      beat(tbl[i].f, tbl[i].l, tbl[i].ramp, tbl[i].tag,
           tbl[i].dv, tbl[i].wv, tbl[i].bv, tbl[i].exp, 1'b1);
    end
    chk("busy_inflight", longint'(busy), 1);
    idle(5);
    chk("busy_idle_after6", longint'(busy), 0);
    drain();
    chk("err_clean_framing", longint'(err_seq), 0);

    // Framing errors
    beat(0, 1, 0, 8'h61, 1, 2, 5, 23, 1'b1);
    @(negedge clk);
    chk("err_rise", longint'(err_seq), 1);
    idle(1);
    beat(1, 0, 0, 8'h00, 1, 1, 100, 0, 1'b1);
    beat(1, 0, 0, 8'h00, 1, 1, 0, 0, 1'b1);
    beat(0, 1, 0, 8'h62, 1, 1, 0, 18, 1'b1);
    drain();
    chk("err_sticky", longint'(err_seq), 1);

    // Saturation: 40-bit instance holds the full sum, 36-bit clamps
    beat(1, 0, 0, 8'h00, -32768, -32768, 0, 0, 1'b1);
    beat(0, 0, 0, 8'h00, -32768, -32768, 0, 0, 1'b1);
    beat(0, 0, 0, 8'h00, -32768, -32768, 0, 0, 1'b1);
    beat(0, 1, 0, 8'h77, -32768, -32768, 0, 64'sd38654705664, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (ov36) begin
        got = 1'b1;
        chk("sat36_result", longint'($signed(res36)), 64'sd34359738367);
        chk("sat36_tag", longint'(tag36), 64'h77);
      end
    end
    if (!got) chk("sat36_timeout", 0, 1);
    idle(1);
    drain();

    // Reset with two beats in flight
    beat(1, 1, 0, 8'h70, 3, 3, 0, 0, 1'b0);
    beat(1, 1, 0, 8'h71, 3, 3, 0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", longint'(out_valid), 0);
    chk("mrst_result", longint'(result), 0);
    chk("mrst_err_seq", longint'(err_seq), 0);
    chk("mrst_busy", longint'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("mrst_no_pulse", longint'(pulses), 0);
    idle(1);

    beat(1, 1, 0, 8'h66, 1, 2, 5, 23, 1'b1);
    drain();
    chk("post_rst_err", longint'(err_seq), 0);
    chk("sb_empty", longint'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
